// File: rtl/map_index_fetch_pkg.sv
// map_pkg: shared map geometry, palette index type and pipeline sideband record.
package map_pkg;
  localparam int MAP_W  = 320;
  localparam int MAP_H  = 240;
  localparam int ADDR_W = 17;
  typedef logic [3:0] pix_index_t;
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic in_map;
  } vga_side_t;
  localparam vga_side_t SIDE_RESET = '{hs: 1'b1, vs: 1'b1, de: 1'b0, in_map: 1'b0};
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: fixed-depth shift register with synchronous reset to RESET_VAL.
module vga_delay_line #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] sr [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= RESET_VAL;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/map_index_fetch.sv
// map_index_fetch: raster coords to map-ROM address, palette index capture and
// sync delay so index and syncs reach the palette LUT on the same cycle.
module map_index_fetch #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int MAP_W = map_pkg::MAP_W,
  parameter int MAP_H = map_pkg::MAP_H,
  parameter int SCALE_SHIFT = 1,
  parameter int ADDR_W = map_pkg::ADDR_W,
  parameter int ROM_LATENCY = 1,
  parameter logic [3:0] BORDER_INDEX = 4'h0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic              de_in,
  input  logic              hs_in,
  input  logic              vs_in,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_q,
  output logic [3:0]        palette_index,
  output logic              index_valid,
  output logic              hs_out,
  output logic              vs_out,
  output logic              de_out,
  output logic              frame_start
);
  import map_pkg::*;
  if (ROM_LATENCY < 1 || ROM_LATENCY > 2 || H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_param_check
    $error("map_index_fetch: unsupported parameter set");
  end
  logic [9:0] mx, my;
  logic       in_map;
  vga_side_t  side_a, side_d;
  pix_index_t idx_next;
  always_comb begin
    mx = draw_x >> SCALE_SHIFT;
    my = draw_y >> SCALE_SHIFT;
    in_map = (32'(mx) < 32'(MAP_W)) && (32'(my) < 32'(MAP_H));
    side_a = '{hs: hs_in, vs: vs_in, de: de_in, in_map: in_map};
    idx_next = side_d.de ? (side_d.in_map ? rom_q : BORDER_INDEX) : '0;
  end
  // Stage A register plus ROM_LATENCY stages keeps the sideband level with rom_q.
  vga_delay_line #(
    .WIDTH(4),
    .DEPTH(ROM_LATENCY + 1),
    .RESET_VAL(SIDE_RESET)
  ) u_side (
    .clk(Clk),
    .rst(Reset),
    .d(side_a),
    .q(side_d)
  );
  // vs_out doubles as the previous-vs register for the frame_start edge detect.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr      <= '0;
      palette_index <= '0;
      index_valid   <= 1'b0;
      de_out        <= 1'b0;
      hs_out        <= 1'b1;
      vs_out        <= 1'b1;
      frame_start   <= 1'b0;
    end else begin
      rom_addr      <= (de_in && in_map) ? ADDR_W'(32'(my) * 32'(MAP_W) + 32'(mx)) : '0;
      palette_index <= idx_next;
      index_valid   <= side_d.de;
      de_out        <= side_d.de;
      hs_out        <= side_d.hs;
      vs_out        <= side_d.vs;
      frame_start   <= vs_out & ~side_d.vs;
    end
  end
endmodule

// File: tb/tb_map_index_fetch.sv
// tb_map_index_fetch: directed vectors on three configurations (default, 2-cycle ROM,
// narrow map with 0xF border) plus reset, latency and sync-alignment sequences.
module tb_map_index_fetch;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic [9:0] draw_x = '0, draw_y = '0;
  logic de_in = 1'b0, hs_in = 1'b1, vs_in = 1'b1;
  logic [16:0] a1, a2, a3;
  logic [3:0] q1, q2, q2p, q3, p1, p2, p3;
  logic v1, v2, v3, h1, h2, h3, s1, s2, s3, d1, d2, d3, f1, f2, f3;
  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    q1  <= a1[3:0];
    q2p <= a2[3:0];
    q2  <= q2p;
    q3  <= a3[3:0];
  end

  map_index_fetch u1 (
    .Clk(Clk), .Reset(Reset), .draw_x(draw_x), .draw_y(draw_y), .de_in(de_in),
    .hs_in(hs_in), .vs_in(vs_in), .rom_addr(a1), .rom_q(q1), .palette_index(p1),
    .index_valid(v1), .hs_out(h1), .vs_out(s1), .de_out(d1), .frame_start(f1)
  );
  map_index_fetch #(.ROM_LATENCY(2)) u2 (
    .Clk(Clk), .Reset(Reset), .draw_x(draw_x), .draw_y(draw_y), .de_in(de_in),
    .hs_in(hs_in), .vs_in(vs_in), .rom_addr(a2), .rom_q(q2), .palette_index(p2),
    .index_valid(v2), .hs_out(h2), .vs_out(s2), .de_out(d2), .frame_start(f2)
  );
  map_index_fetch #(.MAP_W(256), .BORDER_INDEX(4'hF)) u3 (
    .Clk(Clk), .Reset(Reset), .draw_x(draw_x), .draw_y(draw_y), .de_in(de_in),
    .hs_in(hs_in), .vs_in(vs_in), .rom_addr(a3), .rom_q(q3), .palette_index(p3),
    .index_valid(v3), .hs_out(h3), .vs_out(s3), .de_out(d3), .frame_start(f3)
  );

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       de;
    int         a1;
    logic [3:0] i1;
    int         a3;
    logic [3:0] i3;
  } vec_t;
  vec_t vt[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  function automatic logic hs_fn(int n);
    return !(n >= 0 && (n % 200) >= 10 && (n % 200) < 106);
  endfunction

  function automatic logic vs_fn(int n);
    return !(n >= 50 && n < 450);
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_a1"}, a1, 0);  chk({tag, "_a2"}, a2, 0);  chk({tag, "_a3"}, a3, 0);
    chk({tag, "_p1"}, p1, 0);  chk({tag, "_p2"}, p2, 0);  chk({tag, "_p3"}, p3, 0);
    chk({tag, "_v1"}, v1, 0);  chk({tag, "_v2"}, v2, 0);  chk({tag, "_d1"}, d1, 0);
    chk({tag, "_h1"}, h1, 1);  chk({tag, "_s1"}, s1, 1);  chk({tag, "_h2"}, h2, 1);
    chk({tag, "_s2"}, s2, 1);  chk({tag, "_f1"}, f1, 0);
  endtask

  initial begin
    int bh1, bs1, bh2, bs2, bf1, bf2, nf1, nf2, lh1, ls1;
    vt[0] = '{10'd5,    10'd3,    1'b1, 322,   4'h2, 258,  4'h2};
    vt[1] = '{10'd639,  10'd479,  1'b1, 76799, 4'hF, 0,    4'hF};
    vt[2] = '{10'd700,  10'd10,   1'b0, 0,     4'h0, 0,    4'h0};
    vt[3] = '{10'd600,  10'd10,   1'b1, 1900,  4'hC, 0,    4'hF};
    vt[4] = '{10'd0,    10'd0,    1'b1, 0,     4'h0, 0,    4'h0};
    vt[5] = '{10'd640,  10'd0,    1'b1, 0,     4'h0, 0,    4'hF};
    vt[6] = '{10'd0,    10'd480,  1'b1, 0,     4'h0, 0,    4'hF};
    vt[7] = '{10'd17,   10'd9,    1'b1, 1288,  4'h8, 1032, 4'h8};
    vt[8] = '{10'd1023, 10'd1023, 1'b1, 0,     4'h0, 0,    4'hF};
    vt[9] = '{10'd2,    10'd0,    1'b1, 1,     4'h1, 1,    4'h1};

    // reset with active pixels on the inputs
    draw_x = 10'd5; draw_y = 10'd3; de_in = 1'b1;
    repeat (3) tick();
    chk_reset("rst0");
    de_in = 1'b0;
    Reset = 1'b0;
    repeat (5) tick();

    // steady-state vectors
    for (int i = 0; i < 10; i++) begin
      draw_x = vt[i].x; draw_y = vt[i].y; de_in = vt[i].de;
      repeat (5) tick();
      chk($sformatf("v%0d_addr1", i), a1, vt[i].a1);
      chk($sformatf("v%0d_addr2", i), a2, vt[i].a1);
      chk($sformatf("v%0d_addr3", i), a3, vt[i].a3);
      chk($sformatf("v%0d_idx1", i), p1, vt[i].i1);
      chk($sformatf("v%0d_idx2", i), p2, vt[i].i1);
      chk($sformatf("v%0d_idx3", i), p3, vt[i].i3);
      chk($sformatf("v%0d_valid1", i), v1, vt[i].de);
      chk($sformatf("v%0d_valid2", i), v2, vt[i].de);
      chk($sformatf("v%0d_valid3", i), v3, vt[i].de);
      chk($sformatf("v%0d_de3", i), d3, vt[i].de);
      chk($sformatf("v%0d_hs1", i), h1, 1);
      chk($sformatf("v%0d_vs3", i), s3, 1);
    end

    // single-pixel latency: addr at +1, index at +3 (L=3) and +4 (L=4)
    de_in = 1'b0;
    repeat (5) tick();
    draw_x = 10'd5; draw_y = 10'd3; de_in = 1'b1;
    tick();
    chk("lat_addr_p1", a1, 322);
    de_in = 1'b0;
    tick();
    chk("lat_addr_p2", a1, 0);
    chk("lat_valid1_p2", v1, 0);
    tick();
    chk("lat_valid1_p3", v1, 1);
    chk("lat_idx1_p3", p1, 2);
    chk("lat_valid2_p3", v2, 0);
    tick();
    chk("lat_valid1_p4", v1, 0);
    chk("lat_valid2_p4", v2, 1);
    chk("lat_idx2_p4", p2, 2);
    tick();
    chk("lat_valid2_p5", v2, 0);

    // corner pixel through the 2-cycle ROM
    draw_x = 10'd639; draw_y = 10'd479; de_in = 1'b1;
    tick();
    chk("corner_addr2_p1", a2, 76799);
    de_in = 1'b0;
    repeat (2) tick();
    chk("corner_valid2_p3", v2, 0);
    tick();
    chk("corner_valid2_p4", v2, 1);
    chk("corner_idx2_p4", p2, 4'hF);
    repeat (4) tick();

    // reset mid-stream
    draw_x = 10'd5; draw_y = 10'd3; de_in = 1'b1;
    repeat (6) tick();
    chk("stream_valid1", v1, 1);
    Reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_reset($sformatf("mid%0d", k));
    end
    Reset = 1'b0;
    de_in = 1'b0;
    draw_x = 10'd17; draw_y = 10'd9;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("post_valid1_%0d", k), v1, 0);
      chk($sformatf("post_idx1_%0d", k), p1, 0);
      chk($sformatf("post_valid2_%0d", k), v2, 0);
    end
    de_in = 1'b1;
    tick();
    chk("first_valid1_p1", v1, 0);
    tick();
    chk("first_valid1_p2", v1, 0);
    tick();
    chk("first_valid1_p3", v1, 1);
    chk("first_idx1_p3", p1, 8);
    chk("first_valid2_p3", v2, 0);
    tick();
    chk("first_valid2_p4", v2, 1);
    chk("first_idx2_p4", p2, 8);

    // sync alignment: 96-cycle hs pulses, 400-cycle vs pulse
    de_in = 1'b0;
    repeat (6) tick();
    bh1 = 0; bs1 = 0; bh2 = 0; bs2 = 0; bf1 = 0; bf2 = 0;
    nf1 = 0; nf2 = 0; lh1 = 0; ls1 = 0;
    for (int n = 0; n < 600; n++) begin
      hs_in = hs_fn(n); vs_in = vs_fn(n);
      tick();
      if (h1 !== hs_fn(n - 2)) bh1++;
      if (s1 !== vs_fn(n - 2)) bs1++;
      if (h2 !== hs_fn(n - 3)) bh2++;
      if (s2 !== vs_fn(n - 3)) bs2++;
      if (f1 !== (n - 2 == 50)) bf1++;
      if (f2 !== (n - 3 == 50)) bf2++;
      if (f1 === 1'b1) nf1++;
      if (f2 === 1'b1) nf2++;
      if (h1 === 1'b0) lh1++;
      if (s1 === 1'b0) ls1++;
    end
    chk("sync_hs1_misaligned", bh1, 0);
    chk("sync_vs1_misaligned", bs1, 0);
    chk("sync_hs2_misaligned", bh2, 0);
    chk("sync_vs2_misaligned", bs2, 0);
    chk("fs1_misplaced", bf1, 0);
    chk("fs2_misplaced", bf2, 0);
    chk("fs1_count", nf1, 1);
    chk("fs2_count", nf2, 1);
    chk("hs1_low_cycles", lh1, 288);
    chk("vs1_low_cycles", ls1, 400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
